// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the core run controller.
// Holds the controller state encoding and helpers that classify states.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    HALT  = 3'd5
  } ctrl_state_t;

  localparam int WORD_BYTES = 4;

  function automatic logic is_busy(input ctrl_state_t s);
    return s inside {LOAD, START, RUN};
  endfunction

  // HALT keeps the core out of reset so its register file (a0) stays observable.
  function automatic logic holds_core_rst(input ctrl_state_t s);
    return s inside {IDLE, LOAD, START};
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Command, program-load, instruction-memory write and core-control signals
// shared between the run controller (slave) and its environment (master).
interface cpu_run_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 32
);

  logic                  trigger;
  logic                  load_start;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] pc;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [DATA_WIDTH-1:0] imem_wdata;
  logic                  core_rst;
  logic                  core_en;
  logic                  halted;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  cycle_count;

  modport master (
    output trigger, load_start, load_valid, load_data, load_last, pc,
    input  load_ready, imem_we, imem_waddr, imem_wdata,
           core_rst, core_en, halted, busy, cycle_count
  );

  modport slave (
    input  trigger, load_start, load_valid, load_data, load_last, pc,
    output load_ready, imem_we, imem_waddr, imem_wdata,
           core_rst, core_en, halted, busy, cycle_count
  );

endinterface

// File: rtl/cpu_run_ctrl_edge_detect.sv
// Registers a level input and flags the cycle in which it rises.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_q;
  logic in_d;

  always_comb begin
    in_d = in;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_d;
    end
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle core: program load, start, pause/resume
// and jump-to-self halt detection; drives the core's reset and clock-enable.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int HALT_REPEAT = 4,
  parameter int CNT_WIDTH   = 32,
  parameter bit PRELOADED   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  cpu_run_ctrl_if.slave bus
);

  localparam int                    SAME_W    = $clog2(HALT_REPEAT);
  localparam logic [SAME_W-1:0]     SAME_LAST = SAME_W'(HALT_REPEAT - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_STEP  = ADDR_WIDTH'(WORD_BYTES);

  ctrl_state_t           state_q,       state_d;
  logic [ADDR_WIDTH-1:0] ptr_q,         ptr_d;
  logic                  prog_loaded_q, prog_loaded_d;
  logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
  logic [SAME_W-1:0]     same_cnt_q,    same_cnt_d;
  logic [DATA_WIDTH-1:0] pc_q,          pc_d;
  logic                  halted_q,      halted_d;

  logic trig_edge;
  logic pc_same;

  edge_detect u_trig_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (bus.trigger),
    .rise (trig_edge)
  );

  assign pc_same = (bus.pc == pc_q);

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    prog_loaded_d = prog_loaded_q;
    cycle_count_d = cycle_count_q;
    same_cnt_d    = same_cnt_q;
    pc_d          = pc_q;

    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end else if (trig_edge && prog_loaded_q) begin
          state_d = START;
        end
      end

      LOAD: begin
        if (bus.load_valid) begin
          ptr_d = ptr_q + PTR_STEP;
          if (bus.load_last) begin
            prog_loaded_d = 1'b1;
            state_d       = IDLE;
          end
        end
      end

      START: begin
        cycle_count_d = '0;
        same_cnt_d    = '0;
        state_d       = RUN;
      end

      RUN: begin
        cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;
        pc_d          = bus.pc;
        same_cnt_d    = pc_same ? same_cnt_q + 1'b1 : '0;
        // A finished program wins over a pause request arriving in the same cycle.
        if (pc_same && (same_cnt_q == SAME_LAST)) begin
          state_d = HALT;
        end else if (trig_edge) begin
          state_d = PAUSE;
        end
      end

      PAUSE: begin
        if (bus.load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end else if (trig_edge) begin
          state_d = RUN;
        end
      end

      HALT: begin
        if (bus.load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end else if (trig_edge) begin
          state_d = START;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      prog_loaded_q <= PRELOADED;
      cycle_count_q <= '0;
      same_cnt_q    <= '0;
      pc_q          <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      prog_loaded_q <= prog_loaded_d;
      cycle_count_q <= cycle_count_d;
      same_cnt_q    <= same_cnt_d;
      pc_q          <= pc_d;
      halted_q      <= halted_d;
    end
  end

  // Reset reaches core_rst directly so a mid-run reset stops the core at once.
  assign bus.core_rst    = rst | holds_core_rst(state_q);
  assign bus.core_en     = (state_q == RUN);
  assign bus.load_ready  = (state_q == LOAD);
  assign bus.imem_we     = (state_q == LOAD) & bus.load_valid;
  assign bus.imem_waddr  = ptr_q;
  assign bus.imem_wdata  = bus.load_data;
  assign bus.halted      = halted_q;
  assign bus.busy        = is_busy(state_q);
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a vector table for load/start/halt, then
// hand-written sequences for pause/resume, priority, mid-load reset, wrap and saturation.
module tb_cpu_run_ctrl;
  import cpu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .CNT_WIDTH(32)) bm ();
  cpu_run_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4),  .CNT_WIDTH(4))  bs ();

  cpu_run_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(12), .HALT_REPEAT(4), .CNT_WIDTH(32), .PRELOADED(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bm)
  );

  cpu_run_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .HALT_REPEAT(4), .CNT_WIDTH(4), .PRELOADED(1'b0)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bs)
  );

  typedef struct {
    logic        ld_start;
    logic        ld_valid;
    logic        ld_last;
    logic        trig;
    logic [31:0] data;
    logic [31:0] pc;
    ctrl_state_t st;
    logic        we;
    logic        ready;
    logic        crst;
    logic        cen;
    logic        hlt;
    logic        bsy;
    logic        chk_addr;
    logic [11:0] waddr;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input vec_t v);
    bm.load_start = v.ld_start;
    bm.load_valid = v.ld_valid;
    bm.load_last  = v.ld_last;
    bm.trigger    = v.trig;
    bm.load_data  = v.data;
    bm.pc         = v.pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // field order: ld_start ld_valid ld_last trig data pc | st we ready crst cen hlt bsy chk_addr waddr cnt
    vecs[0]  = '{0,0,0,0, 32'h0,        32'h0, IDLE,  0,0,1,0,0,0, 1, 12'h0, 32'd0};
    vecs[1]  = '{1,0,0,0, 32'h0,        32'h0, IDLE,  0,0,1,0,0,0, 1, 12'h0, 32'd0};
    vecs[2]  = '{0,1,0,0, 32'h00500513, 32'h0, LOAD,  1,1,1,0,0,1, 1, 12'h0, 32'd0};
    vecs[3]  = '{1,0,0,1, 32'h0,        32'h0, LOAD,  0,1,1,0,0,1, 1, 12'h4, 32'd0};
    vecs[4]  = '{0,1,0,0, 32'h00150513, 32'h0, LOAD,  1,1,1,0,0,1, 1, 12'h4, 32'd0};
    vecs[5]  = '{0,0,0,0, 32'h0,        32'h0, LOAD,  0,1,1,0,0,1, 1, 12'h8, 32'd0};
    vecs[6]  = '{0,1,1,0, 32'h0000006f, 32'h0, LOAD,  1,1,1,0,0,1, 1, 12'h8, 32'd0};
    vecs[7]  = '{0,0,0,0, 32'h0,        32'h0, IDLE,  0,0,1,0,0,0, 0, 12'h0, 32'd0};
    vecs[8]  = '{0,0,0,1, 32'h0,        32'h0, IDLE,  0,0,1,0,0,0, 0, 12'h0, 32'd0};
    vecs[9]  = '{0,0,0,1, 32'h0,        32'h0, START, 0,0,1,0,0,1, 0, 12'h0, 32'd0};
    vecs[10] = '{0,0,0,0, 32'h0,        32'h0, RUN,   0,0,0,1,0,1, 0, 12'h0, 32'd0};
    vecs[11] = '{0,0,0,0, 32'h0,        32'h4, RUN,   0,0,0,1,0,1, 0, 12'h0, 32'd1};
    vecs[12] = '{0,0,0,0, 32'h0,        32'h8, RUN,   0,0,0,1,0,1, 0, 12'h0, 32'd2};
    vecs[13] = '{0,0,0,0, 32'h0,        32'h8, RUN,   0,0,0,1,0,1, 0, 12'h0, 32'd3};
    vecs[14] = '{0,0,0,0, 32'h0,        32'h8, RUN,   0,0,0,1,0,1, 0, 12'h0, 32'd4};
    vecs[15] = '{0,0,0,0, 32'h0,        32'h8, RUN,   0,0,0,1,0,1, 0, 12'h0, 32'd5};
    vecs[16] = '{0,0,0,0, 32'h0,        32'h8, RUN,   0,0,0,1,0,1, 0, 12'h0, 32'd6};
    vecs[17] = '{0,0,0,0, 32'h0,        32'h8, HALT,  0,0,0,0,1,0, 0, 12'h0, 32'd7};
    vecs[18] = '{0,0,0,0, 32'h0,        32'h8, HALT,  0,0,0,0,1,0, 0, 12'h0, 32'd7};

    bm.trigger = 1'b0; bm.load_start = 1'b0; bm.load_valid = 1'b0;
    bm.load_data = '0; bm.load_last = 1'b0; bm.pc = '0;
    bs.trigger = 1'b0; bs.load_start = 1'b0; bs.load_valid = 1'b0;
    bs.load_data = '0; bs.load_last = 1'b0; bs.pc = '0;

    // Values while reset is held
    #2;
    check("rst core_rst",   32'(bm.core_rst),    32'd1);
    check("rst core_en",    32'(bm.core_en),     32'd0);
    check("rst load_ready", 32'(bm.load_ready),  32'd0);
    check("rst imem_we",    32'(bm.imem_we),     32'd0);
    check("rst waddr",      32'(bm.imem_waddr),  32'd0);
    check("rst halted",     32'(bm.halted),      32'd0);
    check("rst busy",       32'(bm.busy),        32'd0);
    check("rst count",      bm.cycle_count,      32'd0);
    check("rst_s core_rst", 32'(bs.core_rst),    32'd1);
    check("rst_s count",    32'(bs.cycle_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table: gapped 3-word load, trigger start, jump-to-self halt
    for (int i = 0; i < 19; i++) begin
      drive_m(vecs[i]);
      #1;
      check($sformatf("v%0d state", i),      32'(dut.state_q),    32'(vecs[i].st));
      check($sformatf("v%0d imem_we", i),    32'(bm.imem_we),     32'(vecs[i].we));
      check($sformatf("v%0d load_ready", i), 32'(bm.load_ready),  32'(vecs[i].ready));
      check($sformatf("v%0d core_rst", i),   32'(bm.core_rst),    32'(vecs[i].crst));
      check($sformatf("v%0d core_en", i),    32'(bm.core_en),     32'(vecs[i].cen));
      check($sformatf("v%0d halted", i),     32'(bm.halted),      32'(vecs[i].hlt));
      check($sformatf("v%0d busy", i),       32'(bm.busy),        32'(vecs[i].bsy));
      check($sformatf("v%0d count", i),      bm.cycle_count,      vecs[i].cnt);
      if (vecs[i].chk_addr)
        check($sformatf("v%0d waddr", i),    32'(bm.imem_waddr),  32'(vecs[i].waddr));
      if (vecs[i].we)
        check($sformatf("v%0d wdata", i),    bm.imem_wdata,       vecs[i].data);
      tick();
    end

    // Restart from HALT, run to cycle_count=10, then pause
    bm.trigger = 1'b1;
    #1;
    tick();
    bm.trigger = 1'b0;
    #1;
    check("restart state", 32'(dut.state_q), 32'(START));
    tick();
    for (int k = 0; k <= 10; k++) begin
      bm.pc      = 32'h100 + 32'(4 * k);
      bm.trigger = (k == 10);
      #1;
      if (k == 0)  check("rerun count start", bm.cycle_count, 32'd0);
      if (k == 10) check("pre-pause count",   bm.cycle_count, 32'd10);
      tick();
    end
    // Trigger held high for 4 further cycles: still only one edge
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("pause%0d state", k), 32'(dut.state_q), 32'(PAUSE));
      check($sformatf("pause%0d en", k),    32'(bm.core_en),  32'd0);
      check($sformatf("pause%0d count", k), bm.cycle_count,   32'd11);
      tick();
    end
    bm.trigger = 1'b0;
    #1;
    check("pause low count", bm.cycle_count, 32'd11);
    tick();
    bm.trigger = 1'b1;
    bm.pc      = 32'h300;
    #1;
    check("resume edge state", 32'(dut.state_q), 32'(PAUSE));
    tick();
    bm.trigger = 1'b0;
    #1;
    check("resume state", 32'(dut.state_q), 32'(RUN));
    check("resume en",    32'(bm.core_en),  32'd1);
    check("resume count", bm.cycle_count,   32'd11);
    tick();
    #1;
    check("resume count+1", bm.cycle_count, 32'd12);
    tick();
    repeat (3) tick();
    #1;
    check("halt2 state",    32'(dut.state_q),  32'(HALT));
    check("halt2 halted",   32'(bm.halted),    32'd1);
    check("halt2 core_en",  32'(bm.core_en),   32'd0);
    check("halt2 core_rst", 32'(bm.core_rst),  32'd0);
    check("halt2 count",    bm.cycle_count,    32'd16);

    // load_start and trigger edge together in HALT: load wins
    bm.load_start = 1'b1;
    bm.trigger    = 1'b1;
    #1;
    tick();
    bm.load_start = 1'b0;
    bm.trigger    = 1'b0;
    #1;
    check("prio state",    32'(dut.state_q),   32'(LOAD));
    check("prio halted",   32'(bm.halted),     32'd0);
    check("prio ready",    32'(bm.load_ready), 32'd1);
    check("prio waddr",    32'(bm.imem_waddr), 32'd0);
    check("prio core_rst", 32'(bm.core_rst),   32'd1);

    // Reset in the middle of a load
    tick();
    bm.load_valid = 1'b1;
    bm.load_data  = 32'hA0;
    #1;
    check("ml w0 waddr", 32'(bm.imem_waddr), 32'd0);
    tick();
    bm.load_data = 32'hA1;
    #1;
    check("ml w1 waddr", 32'(bm.imem_waddr), 32'd4);
    tick();
    bm.load_data = 32'hA2;
    #1;
    rst = 1'b1;
    #1;
    check("ml rst state", 32'(dut.state_q),   32'(IDLE));
    check("ml rst we",    32'(bm.imem_we),    32'd0);
    check("ml rst ready", 32'(bm.load_ready), 32'd0);
    check("ml rst waddr", 32'(bm.imem_waddr), 32'd0);
    check("ml rst crst",  32'(bm.core_rst),   32'd1);
    check("ml rst busy",  32'(bm.busy),       32'd0);
    tick();
    rst           = 1'b0;
    bm.load_valid = 1'b0;
    bm.load_start = 1'b1;
    #1;
    tick();
    bm.load_start = 1'b0;
    bm.load_valid = 1'b1;
    bm.load_last  = 1'b1;
    bm.load_data  = 32'hB0;
    #1;
    check("reload state", 32'(dut.state_q),   32'(LOAD));
    check("reload we",    32'(bm.imem_we),    32'd1);
    check("reload waddr", 32'(bm.imem_waddr), 32'd0);
    check("reload wdata", bm.imem_wdata,      32'hB0);
    tick();
    bm.load_valid = 1'b0;
    bm.load_last  = 1'b0;
    #1;
    check("reload done", 32'(dut.state_q), 32'(IDLE));

    // Small instance: trigger ignored before any program is loaded
    bs.trigger = 1'b1;
    #1;
    tick();
    bs.trigger = 1'b0;
    #1;
    check("unloaded state", 32'(dut_s.state_q), 32'(IDLE));
    check("unloaded en",    32'(bs.core_en),    32'd0);
    check("unloaded busy",  32'(bs.busy),       32'd0);
    bs.load_start = 1'b1;
    #1;
    tick();
    bs.load_start = 1'b0;
    // Five words into a 16-byte space: the fifth wraps to 0
    for (int k = 0; k < 5; k++) begin
      bs.load_valid = 1'b1;
      bs.load_last  = (k == 4);
      bs.load_data  = 32'(k + 1);
      #1;
      check($sformatf("wrap w%0d we", k),    32'(bs.imem_we),    32'd1);
      check($sformatf("wrap w%0d waddr", k), 32'(bs.imem_waddr), 32'((4 * k) % 16));
      tick();
    end
    bs.load_valid = 1'b0;
    bs.load_last  = 1'b0;
    #1;
    check("wrap done", 32'(dut_s.state_q), 32'(IDLE));
    bs.trigger = 1'b1;
    #1;
    tick();
    bs.trigger = 1'b0;
    #1;
    tick();
    for (int k = 0; k < 20; k++) begin
      bs.pc = 32'(4 * k);
      #1;
      if (k == 15) check("sat count at 15", 32'(bs.cycle_count), 32'd15);
      tick();
    end
    #1;
    check("sat state", 32'(dut_s.state_q),  32'(RUN));
    check("sat count", 32'(bs.cycle_count), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
